hilo_mult_seq: RTL

- Sequencer and HI/LO storage stage that sits directly downstream of the Booth multiplier and between it and the main control unit.
- Accepts a MULT request with operands from the control unit and drives the multiplier's operand and init/stop inputs.
- Counts the fixed multiplier latency, captures the 64-bit product into architectural HI/LO registers, and reports busy/done.
- Also implements MTHI/MTLO writes and MFHI/MFLO readout.

---
 rtl/hilo_mult_seq.sv | 124 ++++++++++++
 1 files changed

// File: rtl/hilo_mult_seq.sv
// hilo_mult_seq: sequencer and HI/LO storage between the control unit and the Booth multiplier.
// It accepts a MULT request, drives the multiplier operands and init/stop, and counts the fixed
// multiplier latency. It then copies the 64-bit product into HI/LO and pulses done. It also
// services MTHI/MTLO writes while no operation is in flight.
//
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   start, op_a, op_b   - MULT request pulse and operands (sampled on acceptance)
//   abort               - flush any in-flight operation
//   mthi, mtlo, wdata   - HI/LO writes, honoured only while not busy
//   mult_a, mult_b      - registered operands to the multiplier
//   mult_init           - one-cycle init pulse to the multiplier (LAUNCH state)
//   mult_stop           - stop/clear to the multiplier (rst | abort)
//   mult_hi, mult_lo    - multiplier result
//   hi_out, lo_out      - architectural HI/LO
//   busy, done          - operation in flight / new HI/LO visible this cycle
module hilo_mult_seq #(
   parameter int unsigned MULT_LATENCY = 35,
   parameter int unsigned CNT_W        = 6
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   input  logic        abort,
   input  logic        mthi,
   input  logic        mtlo,
   input  logic [31:0] wdata,
   output logic [31:0] mult_a,
   output logic [31:0] mult_b,
   output logic        mult_init,
   output logic        mult_stop,
   input  logic [31:0] mult_hi,
   input  logic [31:0] mult_lo,
   output logic [31:0] hi_out,
   output logic [31:0] lo_out,
   output logic        busy,
   output logic        done
);

   typedef enum logic [2:0] {StIdle, StLaunch, StWait, StCapture, StDone} state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      a_q, b_q;
   logic [31:0]      hi_q, lo_q;

   logic idle_like;
   logic accept;
   logic capture;

   // DONE behaves like IDLE for new requests and register writes.
   assign idle_like = (state_q == StIdle) || (state_q == StDone);
   assign accept    = idle_like && start && !abort;
   assign capture   = (state_q == StCapture) && !abort;

   assign busy      = !idle_like;
   assign done      = (state_q == StDone);
   assign mult_init = (state_q == StLaunch);
   assign mult_stop = rst | abort;
   assign mult_a    = a_q;
   assign mult_b    = b_q;
   assign hi_out    = hi_q;
   assign lo_out    = lo_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle, StDone: begin
            state_d = start ? StLaunch : StIdle;
         end
         StLaunch: begin
            cnt_d   = CNT_W'(MULT_LATENCY - 1);
            state_d = StWait;
         end
         StWait: begin
            // Counts MULT_LATENCY-1 down to 0, so WAIT spans exactly MULT_LATENCY cycles.
            if (cnt_q == '0) begin
               state_d = StCapture;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         StCapture: begin
            state_d = StDone;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
      if (abort) begin
         state_d = StIdle;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            a_q <= op_a;
            b_q <= op_b;
         end
         // Capture and register writes never coincide: writes need busy=0.
         if (capture) begin
            hi_q <= mult_hi;
            lo_q <= mult_lo;
         end else if (!busy) begin
            if (mthi) hi_q <= wdata;
            if (mtlo) lo_q <= wdata;
         end
      end
   end

endmodule
